// File: rtl/corr_lag_acc.sv
// Per-lag autocorrelation accumulator. Each sample burst multiplies the
// current sample by its history beats and adds each product into the accumulator for that lag.
module corr_lag_acc #(
    parameter int LAGS  = 32,
    parameter int LAG_W = 5,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smp_valid,
    input  logic [7:0]       smp_data,
    input  logic             hist_valid,
    input  logic [7:0]       hist_data,
    input  logic             rd_en,
    input  logic [LAG_W-1:0] rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [31:0]      nsamp,
    output logic             overrun
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {
        IDLE,
        OPEN
    } burst_state_t;

    burst_state_t     state;
    burst_state_t     state_nxt;

    logic [LAG_W-1:0] lag_cnt;
    logic [7:0]       smp_lat;

    logic             beat_go;
    logic             stray_beat;
    logic             last_beat;
    logic [LAG_W-1:0] beat_lag;
    logic [7:0]       beat_smp;
    logic [15:0]      beat_prod;

    logic             s1_valid;
    logic [LAG_W-1:0] s1_lag;
    logic [15:0]      s1_prod;

    logic [ACC_W-1:0] acc [LAGS];
    logic [SUM_W-1:0] acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A beat that both starts and ends a burst (LAGS == 1) must still close it.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (beat_go && last_beat) begin
            state_nxt = IDLE;
        end else if (smp_valid) begin
            state_nxt = OPEN;
        end
    end

    // A start strobe forwards the new sample and lag 0 to a coincident beat.
    always_comb begin
        beat_go    = 1'b0;
        stray_beat = 1'b0;
        beat_lag   = lag_cnt;
        beat_smp   = smp_lat;
        if (!clr) begin
            if (smp_valid) begin
                beat_lag = '0;
                beat_smp = smp_data;
            end
            if (hist_valid) begin
                if (smp_valid || state == OPEN) begin
                    beat_go = 1'b1;
                end else begin
                    stray_beat = 1'b1;
                end
            end
        end
    end

    assign last_beat = (beat_lag == LAG_W'(LAGS - 1));
    assign beat_prod = 16'(beat_smp) * 16'(hist_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lag_cnt <= '0;
            smp_lat <= '0;
        end else if (clr) begin
            lag_cnt <= '0;
        end else begin
            if (smp_valid) begin
                smp_lat <= smp_data;
            end
            if (beat_go) begin
                lag_cnt <= beat_lag + 1'b1;
            end else if (smp_valid) begin
                lag_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nsamp   <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            nsamp   <= '0;
            overrun <= 1'b0;
        end else begin
            if (smp_valid && nsamp != '1) begin
                nsamp <= nsamp + 32'd1;
            end
            if (stray_beat) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lag   <= '0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= beat_go;
            s1_lag   <= beat_lag;
            s1_prod  <= beat_prod;
        end
    end

    assign acc_sum = {1'b0, acc[s1_lag]} + SUM_W'(s1_prod);

    // clr overrides the stage-2 write, which discards the beat still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAGS; i++) begin
                acc[LAG_W'(i)] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < LAGS; i++) begin
                acc[LAG_W'(i)] <= '0;
            end
        end else if (s1_valid) begin
            acc[s1_lag] <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= acc[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_corr_lag_acc.sv
// Bench for corr_lag_acc: 32-bit and 16-bit accumulator builds share stimulus
// and are compared against a burst-level reference model.
module tb_corr_lag_acc;

    localparam int LAGS  = 32;
    localparam int LAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             smp_valid;
    logic [7:0]       smp_data;
    logic             hist_valid;
    logic [7:0]       hist_data;
    logic             rd_en;
    logic [LAG_W-1:0] rd_addr;

    logic [31:0]      rd_data;
    logic             rd_valid;
    logic [31:0]      nsamp;
    logic             overrun;
    logic [15:0]      rd_data16;
    logic             rd_valid16;
    logic [31:0]      nsamp16;
    logic             overrun16;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    longint unsigned m_acc32 [LAGS];
    longint unsigned m_acc16 [LAGS];
    bit              m_open;
    int              m_next;
    int unsigned     m_smp;
    longint unsigned m_nsamp;
    bit              m_ovr;

    logic [31:0] r32;
    logic [15:0] r16;
    logic        rv32;
    logic        rv16;

    corr_lag_acc #(.LAGS(LAGS), .LAG_W(LAG_W), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .hist_valid(hist_valid), .hist_data(hist_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .nsamp(nsamp), .overrun(overrun)
    );

    corr_lag_acc #(.LAGS(LAGS), .LAG_W(LAG_W), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .hist_valid(hist_valid), .hist_data(hist_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data16), .rd_valid(rd_valid16),
        .nsamp(nsamp16), .overrun(overrun16)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < LAGS; i++) begin
            m_acc32[i] = 0;
            m_acc16[i] = 0;
        end
        m_open  = 1'b0;
        m_next  = 0;
        m_nsamp = 0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_add(input int lag, input longint unsigned p);
        m_acc32[lag] = m_acc32[lag] + p;
        if (m_acc32[lag] > 64'hFFFF_FFFF) m_acc32[lag] = 64'hFFFF_FFFF;
        m_acc16[lag] = m_acc16[lag] + p;
        if (m_acc16[lag] > 64'hFFFF) m_acc16[lag] = 64'hFFFF;
    endfunction

    // One clock cycle of stimulus; the model applies the burst rules directly.
    task automatic drive(input bit sv, input logic [7:0] sd, input bit hv,
                         input logic [7:0] hd, input bit c);
        smp_valid  = sv;
        smp_data   = sd;
        hist_valid = hv;
        hist_data  = hd;
        clr        = c;
        if (c) begin
            for (int i = 0; i < LAGS; i++) begin
                m_acc32[i] = 0;
                m_acc16[i] = 0;
            end
            m_open  = 1'b0;
            m_nsamp = 0;
            m_ovr   = 1'b0;
        end else begin
            if (sv) begin
                m_smp  = sd;
                m_next = 0;
                m_open = 1'b1;
                if (m_nsamp != 64'hFFFF_FFFF) m_nsamp = m_nsamp + 1;
            end
            if (hv) begin
                if (m_open) begin
                    model_add(m_next, longint'(m_smp) * longint'(hd));
                    m_next = m_next + 1;
                    if (m_next == LAGS) m_open = 1'b0;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        smp_valid  = 1'b0;
        smp_data   = 8'd0;
        hist_valid = 1'b0;
        hist_data  = 8'd0;
        clr        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic read_lag(input int a);
        rd_en   = 1'b1;
        rd_addr = LAG_W'(a);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        r32   = rd_data;
        r16   = rd_data16;
        rv32  = rd_valid;
        rv16  = rd_valid16;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; smp_valid = 1'b0; smp_data = 8'd0;
        hist_valid = 1'b0; hist_data = 8'd0; rd_en = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data: got %0h want 0", rd_data); else pass_cnt++;
        chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
        chk_cnt++; if (nsamp !== 32'd0) $display("FAIL reset_nsamp: got %0d want 0", nsamp); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
        chk_cnt++; if ({rd_data16, rd_valid16, nsamp16, overrun16} !== 50'd0)
            $display("FAIL reset_acc16_outputs: got %0h/%b/%0d/%b want all 0", rd_data16, rd_valid16, nsamp16, overrun16);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_burst();
        drive(1'b1, 8'd3, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < LAGS; k++) drive(1'b0, 8'd0, 1'b1, 8'(k + 1), 1'b0);
        idle(3);
        for (int k = 0; k < LAGS; k++) begin
            read_lag(k);
            chk_cnt++; if (r32 !== 32'(3 * (k + 1)) || rv32 !== 1'b1)
                $display("FAIL single_acc[%0d]: got %0d valid %b want %0d valid 1", k, r32, rv32, 3 * (k + 1));
            else pass_cnt++;
            chk_cnt++; if (r16 !== 16'(3 * (k + 1)) || rv16 !== 1'b1)
                $display("FAIL single_acc16[%0d]: got %0d valid %b want %0d", k, r16, rv16, 3 * (k + 1));
            else pass_cnt++;
        end
        chk_cnt++; if (nsamp !== 32'd1) $display("FAIL single_nsamp: got %0d want 1", nsamp); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL single_overrun: got %b want 0", overrun); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, 8'd255, 1'b0, 8'd0, 1'b0);
            for (int k = 0; k < LAGS; k++) drive(1'b0, 8'd0, 1'b1, 8'd255, 1'b0);
        end
        idle(3);
        for (int k = 0; k < LAGS; k++) begin
            read_lag(k);
            chk_cnt++; if (r32 !== 32'd260100) $display("FAIL b2b_acc[%0d]: got %0d want 260100", k, r32); else pass_cnt++;
            chk_cnt++; if (r16 !== 16'hFFFF) $display("FAIL b2b_acc16[%0d]: got %0h want ffff", k, r16); else pass_cnt++;
        end
        chk_cnt++; if (nsamp !== 32'd4) $display("FAIL b2b_nsamp: got %0d want 4", nsamp); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else pass_cnt++;
    endtask

    task automatic test_saturation();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        for (int b = 0; b < 3; b++) begin
            drive(1'b1, 8'd255, 1'b0, 8'd0, 1'b0);
            for (int k = 0; k < LAGS; k++) drive(1'b0, 8'd0, 1'b1, 8'd255, 1'b0);
            idle(3);
            if (b >= 1) begin
                for (int k = 0; k < LAGS; k++) begin
                    read_lag(k);
                    chk_cnt++; if (r16 !== 16'hFFFF)
                        $display("FAIL sat_acc16[%0d] burst %0d: got %0h want ffff", k, b + 1, r16);
                    else pass_cnt++;
                    chk_cnt++; if (r32 !== 32'(65025 * (b + 1)))
                        $display("FAIL sat_acc32[%0d] burst %0d: got %0d want %0d", k, b + 1, r32, 65025 * (b + 1));
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_short_overrun();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd2, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 8'd0, 1'b1, 8'd10, 1'b0);
        drive(1'b1, 8'd2, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < LAGS; k++) drive(1'b0, 8'd0, 1'b1, 8'd10, 1'b0);
        idle(2);
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL short_overrun_early: got %b want 0", overrun); else pass_cnt++;
        drive(1'b0, 8'd0, 1'b1, 8'd10, 1'b0);
        idle(3);
        chk_cnt++; if (overrun !== 1'b1 || overrun16 !== 1'b1)
            $display("FAIL short_overrun_set: got %b/%b want 1/1", overrun, overrun16);
        else pass_cnt++;
        for (int k = 0; k < LAGS; k++) begin
            read_lag(k);
            chk_cnt++; if (r32 !== ((k < 5) ? 32'd40 : 32'd20))
                $display("FAIL short_acc[%0d]: got %0d want %0d", k, r32, (k < 5) ? 40 : 20);
            else pass_cnt++;
        end
        chk_cnt++; if (nsamp !== 32'd2) $display("FAIL short_nsamp: got %0d want 2", nsamp); else pass_cnt++;
    endtask

    task automatic test_clear_priority();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd5, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 7; k++) drive(1'b0, 8'd0, 1'b1, 8'd7, 1'b0);
        rd_en   = 1'b1;
        rd_addr = LAG_W'(3);
        drive(1'b0, 8'd0, 1'b1, 8'd7, 1'b1);
        rd_en = 1'b0;
        chk_cnt++; if (rd_data !== 32'd35 || rd_valid !== 1'b1)
            $display("FAIL clr_read_pre_clear: got %0d valid %b want 35 valid 1", rd_data, rd_valid);
        else pass_cnt++;
        idle(3);
        chk_cnt++; if (nsamp !== 32'd0 || overrun !== 1'b0)
            $display("FAIL clr_counters: got nsamp %0d overrun %b want 0/0", nsamp, overrun);
        else pass_cnt++;
        drive(1'b0, 8'd0, 1'b1, 8'd9, 1'b0);
        idle(3);
        chk_cnt++; if (overrun !== 1'b1) $display("FAIL clr_stray_overrun: got %b want 1", overrun); else pass_cnt++;
        for (int k = 0; k < LAGS; k++) begin
            read_lag(k);
            chk_cnt++; if (r32 !== 32'd0 || r16 !== 16'd0)
                $display("FAIL clr_acc[%0d]: got %0d/%0d want 0", k, r32, r16);
            else pass_cnt++;
        end
    endtask

    task automatic test_read_timing();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd9, 1'b1, 8'd4, 1'b0);
        rd_en   = 1'b1;
        rd_addr = '0;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk_cnt++; if (rd_data !== 32'd0 || rd_valid !== 1'b1)
            $display("FAIL rd_pre_update: got %0d valid %b want 0 valid 1", rd_data, rd_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++; if (rd_valid !== 1'b0 || rd_data !== 32'd0)
            $display("FAIL rd_idle_hold: got %0d valid %b want 0 valid 0", rd_data, rd_valid);
        else pass_cnt++;
        read_lag(0);
        chk_cnt++; if (r32 !== 32'd36) $display("FAIL rd_sim_start_lag0: got %0d want 36", r32); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0 || nsamp !== 32'd1)
            $display("FAIL rd_sim_start_flags: got overrun %b nsamp %0d want 0/1", overrun, nsamp);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        drive(1'b1, 8'd6, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                rd_en   = 1'b1;
                rd_addr = '0;
            end
            drive(1'b0, 8'd0, 1'b1, 8'(k + 1), 1'b0);
            rd_en = 1'b0;
        end
        chk_cnt++; if (rd_data !== 32'd6) $display("FAIL arst_mid_read: got %0d want 6", rd_data); else pass_cnt++;
        hist_valid = 1'b1;
        hist_data  = 8'd11;
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (rd_data !== 32'd0 || rd_data16 !== 16'd0 || nsamp !== 32'd0 || overrun !== 1'b0)
            $display("FAIL arst_immediate: got rd %0d/%0d nsamp %0d overrun %b want 0", rd_data, rd_data16, nsamp, overrun);
        else pass_cnt++;
        hist_valid = 1'b0;
        hist_data  = 8'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(1'b1, 8'd7, 1'b1, 8'd1, 1'b0);
        for (int k = 1; k < LAGS; k++) drive(1'b0, 8'd0, 1'b1, 8'(k + 1), 1'b0);
        idle(3);
        for (int k = 0; k < LAGS; k++) begin
            read_lag(k);
            chk_cnt++; if (r32 !== 32'(7 * (k + 1))) $display("FAIL arst_fresh_acc[%0d]: got %0d want %0d", k, r32, 7 * (k + 1)); else pass_cnt++;
            chk_cnt++; if (r16 !== m_acc16[k][15:0]) $display("FAIL arst_fresh_acc16[%0d]: got %0d want %0d", k, r16, m_acc16[k]); else pass_cnt++;
        end
        chk_cnt++; if (nsamp !== 32'd1) $display("FAIL arst_fresh_nsamp: got %0d want 1", nsamp); else pass_cnt++;
    endtask

    task automatic test_random();
        int len;
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        for (int b = 0; b < 16; b++) begin
            if ($urandom_range(0, 5) == 0) drive(1'b0, 8'd0, 1'b1, 8'($urandom), 1'b0);
            len = int'($urandom_range(1, 34));
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
                len = len - 1;
            end else begin
                drive(1'b1, 8'($urandom), 1'b0, 8'd0, 1'b0);
            end
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                drive(1'b0, 8'd0, 1'b1, 8'($urandom), 1'b0);
            end
        end
        idle(3);
        for (int k = 0; k < LAGS; k++) begin
            read_lag(k);
            chk_cnt++; if (r32 !== m_acc32[k][31:0]) $display("FAIL rand_acc[%0d]: got %0d want %0d", k, r32, m_acc32[k]); else pass_cnt++;
            chk_cnt++; if (r16 !== m_acc16[k][15:0]) $display("FAIL rand_acc16[%0d]: got %0d want %0d", k, r16, m_acc16[k]); else pass_cnt++;
        end
        chk_cnt++; if (nsamp !== m_nsamp[31:0]) $display("FAIL rand_nsamp: got %0d want %0d", nsamp, m_nsamp); else pass_cnt++;
        chk_cnt++; if (overrun !== m_ovr) $display("FAIL rand_overrun: got %b want %b", overrun, m_ovr); else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_saturation();
        test_short_overrun();
        test_clear_priority();
        test_read_timing();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/corr_lag_acc.md
Name: corr_lag_acc

Overview:
- Consumer end of the 8-bit RAM-based shift-register history stream.
- Each sample event delivers the current sample plus a burst of delayed history samples (lag 0 first). This block multiplies the current sample by each history beat and accumulates the product into a per-lag accumulator, giving the raw autocorrelation G(k).
- The accumulators are read back over a simple registered read port and cleared by a single-cycle command.

Parameters:
- LAGS, 32, number of lag channels and the maximum number of beats per burst (power of 2).
- LAG_W, 5, log2(LAGS); width of lag indices.
- ACC_W, 32, accumulator width (at least 16).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of all accumulators and counters.
- smp_valid  in  1  start-of-burst strobe; latches smp_data.
- smp_data  in  8  current sample, unsigned.
- hist_valid  in  1  history beat strobe.
- hist_data  in  8  history sample for the next lag, unsigned.
- rd_en  in  1  readout request.
- rd_addr  in  LAG_W  lag index to read.
- rd_data  out  ACC_W  accumulator value.
- rd_valid  out  1  rd_data is valid.
- nsamp  out  32  number of bursts started since the last clr or reset; saturating.
- overrun  out  1  sticky; set when a burst delivers more than LAGS beats or a beat arrives with no burst open.

Behaviour:
- Reset (async, rst=1): all accumulators, the product pipeline, the lag counter, nsamp, overrun, rd_data and rd_valid go to 0. Latched sample goes to 0. Burst state goes to IDLE.
- Burst states:
  - IDLE: hist_valid beats are dropped and overrun is set.
  - smp_valid in any state: latch smp_data, lag counter := 0, state := OPEN, nsamp += 1 (holds at 0xFFFFFFFF).
  - OPEN: each hist_valid beat is issued with lag = counter, then counter += 1. After beat LAGS-1, state := IDLE.
- Simultaneous smp_valid and hist_valid: the beat is lag 0 and uses the newly presented smp_data. This is not an overrun.
- A new smp_valid mid-burst abandons the remaining lags silently. Already-issued beats still complete.
- Pipeline, with a beat at cycle n:
  - Stage 1 (edge n): prod := smp_latched * hist_data (16-bit unsigned); register the lag and a valid bit.
  - Stage 2 (edge n+1): acc[lag] := acc[lag] + zero-extended prod, saturating at 2^ACC_W-1.
  - Full throughput: one beat per cycle, back-to-back, no stalls. Lags within a burst are distinct, so there is no RAW hazard.
  - Across bursts, the stage-2 write and a stage-1 issue to the same lag are independent, because the accumulate uses acc's current register value at stage 2.
- Readout:
  - rd_en at cycle n gives rd_data = acc[rd_addr] and rd_valid = 1 at edge n. Otherwise rd_valid = 0 and rd_data holds its value.
  - The read samples the register value before any stage-2 write on the same edge, i.e. the pre-update value.
- Clear (clr=1 for one cycle):
  - On the edge, all accumulators := 0, nsamp := 0, overrun := 0, state := IDLE, and both pipeline valid bits := 0 (in-flight beats are discarded).
  - smp_valid and hist_valid in the same cycle are ignored; clr has priority.
  - rd_en in the same cycle returns the pre-clear value.
- Arithmetic is unsigned only; there is no rounding. The saturation flag is not exported; a saturated accumulator sticks at the maximum until clr.
- Latency: 2 cycles from beat to accumulator visible; the readout port adds 1 cycle.

Test Plan:
- Reset then single burst: rst pulse; smp_valid with smp_data=3; 32 beats hist_data=k+1 (k=0..31); wait 3 cycles; read all lags -> acc[k]=3*(k+1), nsamp=1, overrun=0.
- Accumulation and back-to-back bursts: 4 bursts, smp_data=255, all hist_data=255, with the next smp_valid on the cycle after the last beat -> every acc=4*65025=260100, nsamp=4.
- Saturation: ACC_W=16 build; two bursts with 255*255 -> acc[k]=0xFFFF and it holds on a third burst.
- Short burst and overrun: smp_valid, 5 beats, new smp_valid, 32 beats, then one extra beat -> lags 0-4 receive two products, lags 5-31 one; overrun=1 after the extra beat, and the extra beat is not accumulated.
- Clear priority: clr asserted in the cycle of beat lag 7 with another beat in flight -> all acc=0, nsamp=0, overrun=0; a subsequent beat without smp_valid sets overrun=1 and leaves all acc=0.
- Async reset mid-burst: assert rst between clock edges during beat 10 -> outputs are 0 immediately; after release, a fresh burst accumulates correctly from 0.
